// File: rtl/ps2_line_buffer_if.sv
// Bundles the PS/2 key inputs and the line/commit outputs of ps2_line_buffer.
// The master drives scan codes; the slave (the buffer) drives the line state.
interface ps2_line_buffer_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
);
    logic [7:0]         data_PS2key;
    logic               ctrl_PS2pressed;
    logic [8*DEPTH-1:0] line_out;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               overflow;
    logic [8*DEPTH-1:0] line_commit;
    logic               commit_valid;

    modport master (
        output data_PS2key, ctrl_PS2pressed,
        input  line_out, count, full, overflow, line_commit, commit_valid
    );

    modport slave (
        input  data_PS2key, ctrl_PS2pressed,
        output line_out, count, full, overflow, line_commit, commit_valid
    );
endinterface

// File: rtl/ps2_line_buffer.sv
// Turns PS/2 set-2 make codes into an ASCII line with break filtering,
// backspace/enter editing and a registered commit snapshot.
module ps2_line_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    ps2_line_buffer_if.slave  bus
);
    localparam int LW = 8 * DEPTH;

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    logic [7:0]       r_key_q;
    logic             r_pr_q;
    logic             r_pr_q2;
    logic             r_break_pending;
    logic [LW-1:0]    r_line;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_overflow;
    logic [LW-1:0]    r_commit;
    logic             r_commit_valid;

    logic             w_event;
    logic [8:0]       w_ascii;

    // Bit 8 flags a printable key; bits 7:0 carry its ASCII code.
    function automatic logic [8:0] f_to_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 9'h141; 8'h32: return 9'h142; 8'h21: return 9'h143;
            8'h23: return 9'h144; 8'h24: return 9'h145; 8'h2B: return 9'h146;
            8'h34: return 9'h147; 8'h33: return 9'h148; 8'h43: return 9'h149;
            8'h3B: return 9'h14A; 8'h42: return 9'h14B; 8'h4B: return 9'h14C;
            8'h3A: return 9'h14D; 8'h31: return 9'h14E; 8'h44: return 9'h14F;
            8'h4D: return 9'h150; 8'h15: return 9'h151; 8'h2D: return 9'h152;
            8'h1B: return 9'h153; 8'h2C: return 9'h154; 8'h3C: return 9'h155;
            8'h2A: return 9'h156; 8'h1D: return 9'h157; 8'h22: return 9'h158;
            8'h35: return 9'h159; 8'h1A: return 9'h15A;
            8'h45: return 9'h130; 8'h16: return 9'h131; 8'h1E: return 9'h132;
            8'h26: return 9'h133; 8'h25: return 9'h134; 8'h2E: return 9'h135;
            8'h36: return 9'h136; 8'h3D: return 9'h137; 8'h3E: return 9'h138;
            8'h46: return 9'h139;
            8'h29: return 9'h120;
            default: return 9'h000;
        endcase
    endfunction

    assign w_event = r_pr_q & ~r_pr_q2;
    assign w_ascii = f_to_ascii(r_key_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key_q         <= '0;
            r_pr_q          <= 1'b0;
            r_pr_q2         <= 1'b0;
            r_break_pending <= 1'b0;
            r_line          <= '0;
            r_count         <= '0;
            r_full          <= 1'b0;
            r_overflow      <= 1'b0;
            r_commit        <= '0;
            r_commit_valid  <= 1'b0;
        end else begin
            r_key_q        <= bus.data_PS2key;
            r_pr_q         <= bus.ctrl_PS2pressed;
            r_pr_q2        <= r_pr_q;
            r_commit_valid <= 1'b0;

            if (w_event) begin
                if (r_break_pending) begin
                    r_break_pending <= 1'b0;
                end else if (r_key_q == KEY_BREAK) begin
                    r_break_pending <= 1'b1;
                end else if (r_key_q == KEY_EXT) begin
                    r_break_pending <= 1'b0;
                end else if (r_key_q == KEY_BKSP) begin
                    if (r_count != '0) begin
                        r_line     <= {8'h00, r_line[LW-1:8]};
                        r_count    <= r_count - CNT_W'(1);
                        r_full     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end else if (r_key_q == KEY_ENTER) begin
                    r_commit       <= r_line;
                    r_commit_valid <= 1'b1;
                    r_line         <= '0;
                    r_count        <= '0;
                    r_full         <= 1'b0;
                    r_overflow     <= 1'b0;
                end else if (w_ascii[8]) begin
                    // Newest char enters at the LSB byte; oldest drifts toward the MSB.
                    if (r_count < CNT_W'(DEPTH)) begin
                        r_line  <= {r_line[LW-9:0], w_ascii[7:0]};
                        r_count <= r_count + CNT_W'(1);
                        r_full  <= (r_count + CNT_W'(1)) == CNT_W'(DEPTH);
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.line_out     = r_line;
    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.overflow     = r_overflow;
    assign bus.line_commit  = r_commit;
    assign bus.commit_valid = r_commit_valid;
endmodule

// File: tb/tb_ps2_line_buffer.sv
// Scenario-driven bench for ps2_line_buffer: directed spec cases plus a
// randomized key stream compared against a queue-based line model.
module tb_ps2_line_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int LW    = 8 * DEPTH;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ps2_line_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ps2_line_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the line is a queue of ASCII bytes, newest at the back.
    byte unsigned  m_q[$];
    bit            m_brk;
    bit            m_ovf;
    logic [LW-1:0] m_commit;
    int            m_pulse;

    byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    function automatic bit xlate(input byte unsigned code, output byte unsigned a);
        a = 0;
        for (int i = 0; i < 26; i++) if (letter_codes[i] == code) begin a = byte'(65 + i); return 1; end
        for (int i = 0; i < 10; i++) if (digit_codes[i] == code) begin a = byte'(48 + i); return 1; end
        if (code == 8'h29) begin a = 8'h20; return 1; end
        return 0;
    endfunction

    function automatic logic [LW-1:0] m_line();
        logic [LW-1:0] v = '0;
        for (int i = 0; i < m_q.size(); i++)
            v[8*i +: 8] = m_q[m_q.size() - 1 - i];
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_brk    = 0;
        m_ovf    = 0;
        m_commit = '0;
        m_pulse  = 0;
    endtask

    task automatic model_event(input byte unsigned code);
        byte unsigned a;
        m_pulse = 0;
        if (m_brk) m_brk = 0;
        else if (code == 8'hF0) m_brk = 1;
        else if (code == 8'hE0) begin end
        else if (code == 8'h66) begin
            if (m_q.size() > 0) begin void'(m_q.pop_back()); m_ovf = 0; end
        end else if (code == 8'h5A) begin
            m_commit = m_line();
            m_pulse  = 1;
            m_q.delete();
            m_ovf    = 0;
        end else if (xlate(code, a)) begin
            if (m_q.size() < DEPTH) m_q.push_back(a);
            else m_ovf = 1;
        end
    endtask

    // One key press: code presented on the first cycle, garbage afterwards while held.
    task automatic press(input byte unsigned code, input int hold, input int low, output int pulses);
        pulses = 0;
        @(negedge clk);
        bus.data_PS2key     = code;
        bus.ctrl_PS2pressed = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.commit_valid === 1'b1) pulses++;
            bus.data_PS2key = 8'($urandom);
        end
        bus.ctrl_PS2pressed = 1'b0;
        for (int i = 0; i < low; i++) begin
            @(negedge clk);
            if (bus.commit_valid === 1'b1) pulses++;
        end
        model_event(code);
    endtask

    task automatic tap(input byte unsigned code);
        int p;
        press(code, $urandom_range(3, 12), 5, p);
    endtask

    task automatic do_reset();
        bus.ctrl_PS2pressed = 1'b0;
        bus.data_PS2key     = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.line_out !== '0) begin errors++; $display("FAIL reset_line: got %h want 0", bus.line_out); end
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: full %b ovf %b want 0 0", bus.full, bus.overflow); end
        checks++; if (bus.line_commit !== '0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit: got %h/%b want 0/0", bus.line_commit, bus.commit_valid); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        tap(8'h1C); tap(8'h31); tap(8'h23); tap(8'h36);
        checks++; if (bus.line_out !== 32'h414E4436) begin errors++; $display("FAIL fill_line: got %h want 414e4436", bus.line_out); end
        checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_flags: count %0d full %b ovf %b want 4 1 0", bus.count, bus.full, bus.overflow); end
        tap(8'h1C);
        checks++; if (bus.line_out !== 32'h414E4436) begin errors++; $display("FAIL ovf_line: got %h want 414e4436", bus.line_out); end
        checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL ovf_flag: ovf %b count %0d want 1 4", bus.overflow, bus.count); end
        tap(8'h66);
        checks++; if (bus.overflow !== 1'b0 || bus.full !== 1'b0 || bus.line_out !== 32'h00414E44) begin errors++; $display("FAIL ovf_bksp: ovf %b full %b line %h want 0 0 00414e44", bus.overflow, bus.full, bus.line_out); end
    endtask

    task automatic test_break();
        do_reset();
        tap(8'h1C); tap(8'hF0); tap(8'h1C); tap(8'h31);
        checks++; if (bus.line_out !== 32'h0000414E || bus.count !== 3'd2) begin errors++; $display("FAIL break_line: got %h/%0d want 0000414e/2", bus.line_out, bus.count); end
    endtask

    task automatic test_backspace();
        do_reset();
        tap(8'h1C); tap(8'h31); tap(8'h23); tap(8'h66);
        checks++; if (bus.line_out !== 32'h00414E || bus.count !== 3'd2) begin errors++; $display("FAIL bksp_one: got %h/%0d want 00414e/2", bus.line_out, bus.count); end
        tap(8'h66); tap(8'h66); tap(8'h66);
        checks++; if (bus.line_out !== '0 || bus.count !== 3'd0) begin errors++; $display("FAIL bksp_empty: got %h/%0d want 0/0", bus.line_out, bus.count); end
    endtask

    task automatic test_enter();
        int p;
        do_reset();
        tap(8'h1C); tap(8'h31); tap(8'h23);
        press(8'h5A, 4, 5, p);
        checks++; if (p != 1) begin errors++; $display("FAIL enter_pulse: got %0d cycles want 1", p); end
        checks++; if (bus.line_commit !== 32'h00414E44) begin errors++; $display("FAIL enter_commit: got %h want 00414e44", bus.line_commit); end
        checks++; if (bus.line_out !== '0 || bus.count !== 3'd0) begin errors++; $display("FAIL enter_clear: got %h/%0d want 0/0", bus.line_out, bus.count); end
        press(8'h5A, 2, 5, p);
        checks++; if (p != 1 || bus.line_commit !== '0) begin errors++; $display("FAIL enter_empty: pulse %0d commit %h want 1 0", p, bus.line_commit); end
    endtask

    task automatic test_long_hold();
        int p;
        do_reset();
        press(8'h16, 200, 5, p);
        checks++; if (bus.line_out !== 32'h31 || bus.count !== 3'd1) begin errors++; $display("FAIL hold_line: got %h/%0d want 00000031/1", bus.line_out, bus.count); end
        tap(8'hE0); tap(8'h05);
        checks++; if (bus.line_out !== 32'h31 || bus.count !== 3'd1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL ignored_codes: got %h/%0d/%b want 00000031/1/0", bus.line_out, bus.count, bus.overflow); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tap(8'h1C); tap(8'h31); tap(8'h23); tap(8'hF0);
        @(negedge clk);
        bus.data_PS2key     = 8'h1C;
        bus.ctrl_PS2pressed = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.line_out !== '0 || bus.count !== '0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL async_line: got %h/%0d/%b/%b want all 0", bus.line_out, bus.count, bus.full, bus.overflow); end
        checks++; if (bus.line_commit !== '0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL async_commit: got %h/%b want 0/0", bus.line_commit, bus.commit_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_event(8'h1C);
        repeat (4) @(negedge clk);
        checks++; if (bus.line_out !== 32'h41 || bus.count !== 3'd1) begin errors++; $display("FAIL async_held: got %h/%0d want 00000041/1", bus.line_out, bus.count); end
        bus.ctrl_PS2pressed = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int p;
        byte unsigned code;
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 11))
                0:       code = 8'hF0;
                1:       code = 8'hE0;
                2, 3:    code = 8'h66;
                4:       code = 8'h5A;
                5:       code = 8'($urandom);
                11:      code = 8'h29;
                default: code = ($urandom_range(0, 2) == 0) ? digit_codes[$urandom_range(0, 9)]
                                                            : letter_codes[$urandom_range(0, 25)];
            endcase
            press(code, $urandom_range(1, 6), $urandom_range(2, 4), p);
            checks++; if (p != m_pulse) begin errors++; $display("FAIL rnd_pulse[%0d] code %h: got %0d want %0d", n, code, p, m_pulse); end
            checks++; if (bus.line_out !== m_line() || bus.count !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rnd_line[%0d] code %h: got %h/%0d want %h/%0d", n, code, bus.line_out, bus.count, m_line(), m_q.size()); end
            checks++; if (bus.full !== (m_q.size() == DEPTH) || bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_flags[%0d] code %h: full %b ovf %b want %b %b", n, code, bus.full, bus.overflow, m_q.size() == DEPTH, m_ovf); end
            checks++; if (bus.line_commit !== m_commit) begin errors++; $display("FAIL rnd_commit[%0d] code %h: got %h want %h", n, code, bus.line_commit, m_commit); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.ctrl_PS2pressed = 1'b0;
        bus.data_PS2key     = 8'h00;
        model_reset();
        test_reset();
        test_fill_overflow();
        test_break();
        test_backspace();
        test_enter();
        test_long_hold();
        test_async_reset();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_line_buffer.md
# ps2_line_buffer

Parametrised keyboard line buffer that turns PS/2 set-2 scan-code events into a line of ASCII characters. It replaces the fixed four-character fill with:
- configurable depth;
- break-code filtering;
- backspace and enter editing;
- a committed-line output with a one-cycle valid strobe.

It sits between the PS/2 receiver (`data_PS2key`/`ctrl_PS2pressed`) and the command parser and display logic.

## Interface
Parameters:
- `DEPTH`, 4 — number of characters held (≥2).
- `CNT_W`, 3 — width of `count`; must satisfy 2^CNT_W > DEPTH.

Ports:
- `clock`  in  1 — rising-edge clock.
- `reset`  in  1 — asynchronous, active-high; clears all state.
- `data_PS2key`  in  8 — scan code from the PS/2 receiver.
- `ctrl_PS2pressed`  in  1 — high while a code is presented; may be held high for many cycles.
- `line_out`  out  8*DEPTH — live buffer; newest char in `[7:0]`, older chars toward the MSB, unused bytes 0x00.
- `count`  out  CNT_W — number of valid chars, 0..DEPTH.
- `full`  out  1 — `count == DEPTH`.
- `overflow`  out  1 — sticky; a printable char was dropped while full.
- `line_commit`  out  8*DEPTH — snapshot of `line_out` taken at enter.
- `commit_valid`  out  1 — one-cycle pulse when `line_commit` updates.

## Operation
**Input stage**
- `data_PS2key` and `ctrl_PS2pressed` are registered every cycle into `key_q` and `pr_q`; `pr_q2` holds the previous `pr_q`.
- Event = `pr_q & ~pr_q2`. Exactly one event per low→high of `ctrl_PS2pressed`, regardless of hold length.

**Decode, per event, priority order**
1. `break_pending` set: clear it, ignore the code.
2. Code 0xF0: set `break_pending`.
3. Code 0xE0: ignore, no state change.
4. Code 0x66 (backspace): if `count > 0`, shift buffer right one byte (MSB byte ← 0x00), `count−1`, clear `overflow`. Otherwise no-op.
5. Code 0x5A (enter): `line_commit ← line_out`, `commit_valid = 1`, clear buffer, `count`, `overflow`. This applies even when `count = 0`, which produces a commit of all-zeros.
6. Printable code: translate to ASCII.
   - Letters (set-2) → uppercase 0x41–0x5A, e.g. 1C→41, 32→42, 21→43, 23→44, 31→4E, 1A→5A.
   - Digits 45,16,1E,26,25,2E,36,3D,3E,46 → 0x30–0x39.
   - 0x29 → 0x20 (space).
   - If `count < DEPTH`: shift buffer left one byte, `[7:0]` ← ASCII, `count+1`. Otherwise drop the char and set `overflow`.
7. Any other code: ignored.

**Invariants and reset**
- Bytes at index ≥ `count` are always 0x00.
- Reset mid-operation (including with `break_pending` set or `ctrl_PS2pressed` held high) clears everything.
- After reset releases with `ctrl_PS2pressed` already high: because `pr_q2` resets to 0, one event fires on the held key.

## Timing
- Reset values: `line_out`=0, `count`=0, `full`=0, `overflow`=0, `line_commit`=0, `commit_valid`=0, `break_pending`=0, `pr_q`/`pr_q2`/`key_q`=0.
- Edge k first samples `ctrl_PS2pressed`=1. Edge k+1 updates `line_out`, `count`, `full` and `overflow`. Latency is 2 edges from the input rising.
- On enter, `commit_valid` is high for exactly the cycle after edge k+1. `line_commit` holds its value until the next enter or reset.
- `data_PS2key` must be stable at edge k; later changes while held are ignored.
- Minimum event spacing: `ctrl_PS2pressed` must be low for at least 1 sampled cycle between events.
- All outputs are registered; no combinational input-to-output path.

## Test plan
1. **Fill and overflow (DEPTH=4).** After reset, press 1C, 31, 23, 36 (each held 3–12 cycles, low ≥5 between).
   - Required: `line_out` = 41_4E_44_36, `count`=4, `full`=1, `overflow`=0.
   - Then press 1C again: `line_out` unchanged, `overflow`=1.
2. **Break filtering.** Sequence 1C, F0, 1C, 31.
   - Required: `line_out` = 00_00_41_4E, `count`=2. The 1C following F0 produces no char.
3. **Backspace.** Starting from 41_4E_44, press 66 → 00_41_4E, `count`=2.
   - Press 66 three more times → all zeros, `count`=0. The extra press is a no-op; no underflow wrap.
4. **Enter.** Starting from 41_4E_44, press 5A.
   - Required: `commit_valid` high one cycle, `line_commit` = 00_41_4E_44, `line_out`=0, `count`=0.
   - Enter on empty: commit of 0 with `commit_valid` pulse.
5. **Long hold / ignored codes.** Hold `ctrl_PS2pressed` high 200 cycles with 0x16 → exactly one 0x31 appended.
   - Codes E0 and 0x05 → no change.
6. **Async reset mid-operation.** Assert `reset` mid-cycle with `count`=3 and `break_pending`=1.
   - Required: all outputs 0 immediately.
   - After release, with `ctrl_PS2pressed` held at 0x1C, one char 0x41 appears; it is not suppressed by the stale break state.
